// File: rtl/psum_dequant_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : psum_dequant_accumulator
// Description : Dequantizes a stored 8-bit psum back into the 21-bit psum
//               domain (sign-extend, shift left by SHIFT), accumulates up to
//               ACC_LEN signed products onto it and emits the 21-bit psum
//               through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_dequant_accumulator #(
    parameter int ACC_LEN = 6,
    parameter int SHIFT   = 10,
    parameter int PROD_W  = 16,
    parameter int OUT_W   = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        acc_len,
    input  logic              use_prev,
    input  logic [7:0]        psum_in,
    input  logic              psum_in_valid,
    output logic              psum_in_ready,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_in_valid,
    output logic              prod_in_ready,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              busy
);

    localparam logic [2:0] c_max_len = 3'(ACC_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_len;
    logic [2:0]        r_count;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_data_out;

    logic              w_psum_ready;
    logic              w_prod_ready;
    logic              w_out_valid;
    logic [2:0]        w_len_clamped;
    logic [2:0]        w_count_inc;
    logic [OUT_W-1:0]  w_dequant;
    logic [OUT_W-1:0]  w_prod_ext;
    logic [OUT_W-1:0]  w_acc_sum;

    // Stored byte lands in bits [SHIFT+7:SHIFT] so the requantizer slice returns it unchanged
    assign w_dequant     = {{(OUT_W-8){psum_in[7]}}, psum_in} << SHIFT;
    assign w_prod_ext    = {{(OUT_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign w_acc_sum     = r_acc + w_prod_ext;
    assign w_count_inc   = r_count + 3'd1;
    assign w_len_clamped = (acc_len > c_max_len) ? c_max_len : acc_len;

    // Next-state and handshake outputs; a zero-length job with a previous psum skips ACC
    always_comb begin
        w_state_next = r_state;
        w_psum_ready = 1'b0;
        w_prod_ready = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = use_prev ? ST_LOAD : ST_ACC;
                end
            end
            ST_LOAD: begin
                w_psum_ready = 1'b1;
                if (psum_in_valid) begin
                    w_state_next = (r_len == 3'd0) ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                w_prod_ready = (r_count < r_len);
                if (!w_prod_ready) begin
                    w_state_next = ST_OUT;
                end else if (prod_in_valid && (w_count_inc == r_len)) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (data_out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: job length latch, accumulator, product counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= 3'd0;
            r_count    <= 3'd0;
            r_acc      <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_count <= 3'd0;
                        r_acc   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (psum_in_valid) begin
                        r_acc <= w_dequant;
                        if (r_len == 3'd0) begin
                            r_data_out <= w_dequant;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_prod_ready && prod_in_valid) begin
                        r_acc   <= w_acc_sum;
                        r_count <= w_count_inc;
                        if (w_count_inc == r_len) begin
                            r_data_out <= w_acc_sum;
                        end
                    end else if (!w_prod_ready) begin
                        r_data_out <= r_acc;
                    end
                end
                ST_OUT: begin
                    if (data_out_ready) begin
                        r_count <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign psum_in_ready  = w_psum_ready;
    assign prod_in_ready  = w_prod_ready;
    assign data_out_valid = w_out_valid;
    assign data_out       = r_data_out;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psum_dequant_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_dequant_accumulator
// Description : Directed self-checking bench for psum_dequant_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_dequant_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  acc_len;
    logic        use_prev;
    logic [7:0]  psum_in;
    logic        psum_in_valid;
    logic        psum_in_ready;
    logic [15:0] prod_in;
    logic        prod_in_valid;
    logic        prod_in_ready;
    logic [20:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        busy;

    int total;
    int bad;

    psum_dequant_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .acc_len        (acc_len),
        .use_prev       (use_prev),
        .psum_in        (psum_in),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .prod_in        (prod_in),
        .prod_in_valid  (prod_in_valid),
        .prod_in_ready  (prod_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start for one cycle; on return the DUT is in LOAD or ACC
    task automatic do_start(input logic prev, input logic [2:0] len);
        start    = 1'b1;
        use_prev = prev;
        acc_len  = len;
        tick();
        start = 1'b0;
    endtask

    // Consume the result and return to IDLE
    task automatic drain();
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0 || psum_in_ready !== 1'b0 ||
            prod_in_ready !== 1'b0 || data_out !== 21'd0) begin
            bad++;
            $display("FAIL reset: busy=%b valid=%b pr=%b qr=%b data=%0d required all 0",
                     busy, data_out_valid, psum_in_ready, prod_in_ready, data_out);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_start(1'b1, 3'd3);
        total++;
        if (psum_in_ready !== 1'b1 || prod_in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_ready: psum_ready=%b prod_ready=%b busy=%b required 1 0 1",
                     psum_in_ready, prod_in_ready, busy);
        end
        // product offered during LOAD must be ignored
        prod_in = 16'd9999; prod_in_valid = 1'b1;
        psum_in = 8'd3;     psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        prod_in = 16'd100;
        tick();
        prod_in = 16'd200;
        tick();
        total++;
        if (data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: valid=%b required 0", data_out_valid);
        end
        prod_in = -16'sd50;
        tick();
        prod_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1 || data_out !== 21'd3322 || data_out[17:10] !== 8'd3) begin
            bad++;
            $display("FAIL basic_result: valid=%b data=%0d required 1 3322", data_out_valid, data_out);
        end
        drain();
        total++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: busy=%b valid=%b required 0 0", busy, data_out_valid);
        end
    endtask

    task automatic test_full_length();
        do_start(1'b1, 3'd6);
        psum_in = 8'hFE; psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        prod_in = 16'd16384; prod_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        prod_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1 || data_out !== 21'd96256) begin
            bad++;
            $display("FAIL full_length: valid=%b data=%0d required 1 96256", data_out_valid, data_out);
        end
        drain();
    endtask

    task automatic test_round_trip();
        do_start(1'b1, 3'd0);
        psum_in = 8'h80; psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1 || data_out !== 21'h1E0000 || data_out[17:10] !== 8'h80) begin
            bad++;
            $display("FAIL round_trip: valid=%b data=%h required 1 1e0000", data_out_valid, data_out);
        end
        drain();
    endtask

    task automatic test_clamp();
        logic [15:0] vec [7];
        int accepted;
        vec[0] = 16'd1000;  vec[1] = -16'sd2000; vec[2] = 16'd3000;
        vec[3] = -16'sd4000; vec[4] = 16'd5000; vec[5] = -16'sd6000; vec[6] = 16'd7777;
        accepted = 0;
        do_start(1'b0, 3'd7);
        prod_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (prod_in_ready === 1'b1 && accepted < 7) begin
                prod_in = vec[accepted];
                accepted++;
            end else begin
                prod_in = 16'd7777;
            end
            tick();
        end
        prod_in_valid = 1'b0;
        total++;
        if (accepted != 6) begin
            bad++;
            $display("FAIL clamp_count: accepted=%0d required 6", accepted);
        end
        total++;
        if (data_out_valid !== 1'b1 || data_out !== 21'h1FF448 || prod_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL clamp_sum: valid=%b data=%h prod_ready=%b required 1 1ff448 0",
                     data_out_valid, data_out, prod_in_ready);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        do_start(1'b0, 3'd1);
        prod_in = 16'd5; prod_in_valid = 1'b1;
        tick();
        prod_in_valid = 1'b0;
        start = 1'b1; use_prev = 1'b1; acc_len = 3'd2;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (data_out_valid !== 1'b1 || data_out !== 21'd5 || busy !== 1'b1 || psum_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: valid=%b data=%0d busy=%b psum_ready=%b required 1 5 1 0",
                         c, data_out_valid, data_out, busy, psum_in_ready);
            end
            tick();
        end
        data_out_ready = 1'b1;
        tick();
        start = 1'b0;
        data_out_ready = 1'b0;
        total++;
        if (data_out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 21'd5) begin
            bad++;
            $display("FAIL release: valid=%b busy=%b data=%0d required 0 0 5", data_out_valid, busy, data_out);
        end
        tick();
        total++;
        if (busy !== 1'b0 || psum_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored: busy=%b psum_ready=%b required 0 0", busy, psum_in_ready);
        end
    endtask

    task automatic test_mid_reset();
        do_start(1'b1, 3'd4);
        psum_in = 8'd1; psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        prod_in = 16'd11; prod_in_valid = 1'b1;
        tick();
        tick();
        prod_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0 || prod_in_ready !== 1'b0 || data_out !== 21'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b valid=%b prod_ready=%b data=%0d required 0 0 0 0",
                     busy, data_out_valid, prod_in_ready, data_out);
        end
        tick();
        rst = 1'b0;
        tick();
        do_start(1'b0, 3'd2);
        prod_in = 16'd7; prod_in_valid = 1'b1;
        tick();
        prod_in = 16'd8;
        tick();
        prod_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1 || data_out !== 21'd15) begin
            bad++;
            $display("FAIL after_reset: valid=%b data=%0d required 1 15", data_out_valid, data_out);
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        start = 1'b0; acc_len = 3'd0; use_prev = 1'b0;
        psum_in = 8'd0; psum_in_valid = 1'b0;
        prod_in = 16'd0; prod_in_valid = 1'b0;
        data_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_length();
        test_round_trip();
        test_clamp();
        test_back_pressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
